// File: rtl/adat_i2s_serializer.sv
// Reads decoded ADAT frames from the channel buffer and serialises the 8 channels
// as four stereo I2S lanes (64 BCLK per frame, 24-bit MSB-first samples in 32-bit slots).
module adat_i2s_serializer #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int FRAME_LAG     = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic [CIRC_BUF_BITS+7:0] read_addr_o,
  input  logic                     read_data_i,
  input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
  input  logic                     has_sync_i,
  output logic                     bclk_o,
  output logic                     lrclk_o,
  output logic [3:0]               sdata_o,
  output logic                     frame_start_o
);

  localparam logic [CIRC_BUF_BITS-1:0] LAG = CIRC_BUF_BITS'(FRAME_LAG);

  logic [3:0]               r_phase;
  logic [5:0]               r_slot;
  logic [3:0]               r_stage;
  logic [CIRC_BUF_BITS-1:0] r_frame;
  logic                     r_mute;

  logic [5:0]               w_tgt_slot;
  logic [4:0]               w_j;
  logic [4:0]               w_bit_idx;
  logic                     w_bit_valid;
  logic [3:0]               w_cap_idx;
  logic [1:0]               w_cap_lane;
  logic                     w_addr_phase;
  logic                     w_cap_phase;
  logic                     w_slot_start;
  logic                     w_latch;
  logic [CIRC_BUF_BITS-1:0] w_lag_frame;

  // Fetches in slot s prepare the bits shown in slot s+1; slot bit j carries sample bit j-1.
  always_comb begin
    w_tgt_slot   = r_slot + 6'd1;
    w_j          = w_tgt_slot[4:0];
    w_bit_idx    = w_j - 5'd1;
    w_bit_valid  = (w_j != 5'd0) && (w_j <= 5'd24);
    w_cap_idx    = r_phase - 4'd2;
    w_cap_lane   = w_cap_idx[1:0];
    w_addr_phase = (r_phase <= 4'd3);
    w_cap_phase  = (r_phase >= 4'd2) && (r_phase <= 4'd5);
    w_slot_start = (r_phase == 4'd0);
    w_latch      = w_slot_start && (r_slot == 6'd63);
    w_lag_frame  = last_good_frame_idx_i - LAG;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_phase       <= 4'd0;
      r_slot        <= 6'd0;
      r_stage       <= 4'd0;
      r_frame       <= '0;
      r_mute        <= 1'b1;
      read_addr_o   <= '0;
      bclk_o        <= 1'b0;
      lrclk_o       <= 1'b0;
      sdata_o       <= 4'd0;
      frame_start_o <= 1'b0;
    end else begin
      r_phase       <= r_phase + 4'd1;
      if (r_phase == 4'd15) begin
        r_slot <= r_slot + 6'd1;
      end
      bclk_o        <= r_phase[3];
      frame_start_o <= w_slot_start && (r_slot == 6'd0);

      if (w_slot_start) begin
        lrclk_o <= r_slot[5];
        sdata_o <= r_mute ? 4'd0 : r_stage;
      end

      // Lane L address goes out at phase L, its data returns one clk later.
      if (w_addr_phase) begin
        read_addr_o <= {r_frame, r_phase[1:0], w_tgt_slot[5], w_bit_idx};
      end
      if (w_cap_phase) begin
        r_stage[w_cap_lane] <= w_bit_valid & read_data_i;
      end

      // Slot 63 fetches for slot 0, which is always zero, so relatching here is safe.
      if (w_latch) begin
        r_frame <= w_lag_frame;
        r_mute  <= ~has_sync_i;
      end
    end
  end

endmodule
